// File: rtl/text_fetch8x12.sv
// Text-mode pixel stage: character/attribute fetch, glyph fetch, palette lookup and
// blinking underline cursor, with a fixed 5-cycle latency and matching delayed syncs.
module text_fetch8x12 #(
    parameter int HRES       = 640,
    parameter int VRES       = 480,
    parameter int HSZ        = 10,
    parameter int VSZ        = 10,
    parameter int COLS       = 80,
    parameter int CELL_H     = 12,
    parameter int BLINK_LOG2 = 5
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [HSZ-1:0] i_hcount,
    input  logic [VSZ-1:0] i_vcount,
    input  logic           i_de,
    input  logic           i_hsync,
    input  logic           i_vsync,
    output logic [11:0]    o_text_addr,
    input  logic [15:0]    i_text_data,
    output logic [11:0]    o_font_addr,
    input  logic [7:0]     i_font_data,
    input  logic           i_pal_we,
    input  logic [3:0]     i_pal_idx,
    input  logic [11:0]    i_pal_color,
    input  logic           i_cursor_en,
    input  logic [6:0]     i_cursor_col,
    input  logic [5:0]     i_cursor_row,
    output logic [11:0]    o_color,
    output logic           o_de,
    output logic           o_hsync,
    output logic           o_vsync
);
    localparam int FW = BLINK_LOG2 + 1;

    logic [3:0]    cell_row;
    logic [5:0]    text_row;
    logic [11:0]   row_base;
    logic [FW-1:0] frame_cnt;

    logic [6:0] col;
    logic       line_end;
    logic       frame_end;
    logic       cursor_hit;

    assign col       = 7'(i_hcount[HSZ-1:3]);
    assign line_end  = (i_hcount == HSZ'(HRES - 1));
    assign frame_end = (i_vcount == VSZ'(VRES - 1));

    // Cursor is an underline on the bottom two scanlines of its cell, blinking on frame_cnt.
    assign cursor_hit = i_cursor_en && frame_cnt[BLINK_LOG2]
                        && (text_row == i_cursor_row) && (col == i_cursor_col)
                        && (cell_row >= 4'(CELL_H - 2));

    // NOTE: all state below uses non-blocking assignments so every stage samples the
    // previous value of its neighbour; blocking here would collapse the pipeline.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cell_row  <= '0;
            text_row  <= '0;
            row_base  <= '0;
            frame_cnt <= '0;
        end else if (line_end) begin
            if (frame_end) begin
                cell_row  <= '0;
                text_row  <= '0;
                row_base  <= '0;
                frame_cnt <= frame_cnt + FW'(1);
            end else if (cell_row == 4'(CELL_H - 1)) begin
                cell_row <= '0;
                text_row <= text_row + 6'd1;
                row_base <= row_base + 12'(COLS);
            end else begin
                cell_row <= cell_row + 4'd1;
            end
        end
    end

    logic [11:0] palette [16];

    // NOTE: the palette is a 16-entry flop array rather than a RAM macro, so it can be
    // loaded with the grey ramp in reset; larger memories should not be reset this way.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= {4'(i), 4'(i), 4'(i)};
            end
        end else if (i_pal_we) begin
            palette[i_pal_idx] <= i_pal_color;
        end
    end

    logic [2:0] h1, h2, h3, h4;
    logic [3:0] row1, row2;
    logic       cur1, cur2, cur3, cur4;
    logic [7:0] attr3, attr4;
    logic [4:0] de_sr, hs_sr, vs_sr;

    logic       pix_bit;
    logic [3:0] pal_idx;

    assign pix_bit = i_font_data[3'd7 - h4];
    assign pal_idx = (pix_bit ^ cur4) ? attr4[7:4] : attr4[3:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            o_text_addr <= '0;
            o_font_addr <= '0;
            o_color     <= '0;
            h1    <= '0;
            h2    <= '0;
            h3    <= '0;
            h4    <= '0;
            row1  <= '0;
            row2  <= '0;
            cur1  <= 1'b0;
            cur2  <= 1'b0;
            cur3  <= 1'b0;
            cur4  <= 1'b0;
            attr3 <= '0;
            attr4 <= '0;
            de_sr <= '0;
            hs_sr <= '0;
            vs_sr <= '0;
        end else begin
            // Stage 1: text RAM address holds through blanking.
            if (i_de) begin
                o_text_addr <= row_base + 12'(col);
            end
            h1   <= i_hcount[2:0];
            row1 <= cell_row;
            cur1 <= cursor_hit;

            h2   <= h1;
            row2 <= row1;
            cur2 <= cur1;

            // Stage 3: text data is valid, issue the glyph row fetch.
            o_font_addr <= {i_text_data[7:0], row2};
            attr3       <= i_text_data[15:8];
            h3          <= h2;
            cur3        <= cur2;

            attr4 <= attr3;
            h4    <= h3;
            cur4  <= cur3;

            // Stage 5: glyph data is valid, colour out.
            o_color <= de_sr[3] ? palette[pal_idx] : 12'h000;

            de_sr <= {de_sr[3:0], i_de};
            hs_sr <= {hs_sr[3:0], i_hsync};
            vs_sr <= {vs_sr[3:0], i_vsync};
        end
    end

    assign o_de    = de_sr[4];
    assign o_hsync = hs_sr[4];
    assign o_vsync = vs_sr[4];

endmodule

// File: tb/tb_text_fetch8x12.sv
// Scoreboard bench for text_fetch8x12: sparse timing-core stimulus, behavioural RAM/ROM,
// and a line/frame model that predicts address, glyph and colour for every pixel.
module tb_text_fetch8x12;
    localparam int HRES       = 640;
    localparam int VRES       = 480;
    localparam int COLS       = 80;
    localparam int CELL_H     = 12;
    localparam int BLINK_LOG2 = 5;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic [9:0]  i_hcount = '0;
    logic [9:0]  i_vcount = '0;
    logic        i_de = 1'b0;
    logic        i_hsync = 1'b0;
    logic        i_vsync = 1'b0;
    logic [11:0] o_text_addr;
    logic [15:0] i_text_data;
    logic [11:0] o_font_addr;
    logic [7:0]  i_font_data;
    logic        i_pal_we = 1'b0;
    logic [3:0]  i_pal_idx = '0;
    logic [11:0] i_pal_color = '0;
    logic        i_cursor_en = 1'b0;
    logic [6:0]  i_cursor_col = '0;
    logic [5:0]  i_cursor_row = '0;
    logic [11:0] o_color;
    logic        o_de;
    logic        o_hsync;
    logic        o_vsync;

    always #5 clk_i = ~clk_i;

    text_fetch8x12 dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .i_hcount     (i_hcount),
        .i_vcount     (i_vcount),
        .i_de         (i_de),
        .i_hsync      (i_hsync),
        .i_vsync      (i_vsync),
        .o_text_addr  (o_text_addr),
        .i_text_data  (i_text_data),
        .o_font_addr  (o_font_addr),
        .i_font_data  (i_font_data),
        .i_pal_we     (i_pal_we),
        .i_pal_idx    (i_pal_idx),
        .i_pal_color  (i_pal_color),
        .i_cursor_en  (i_cursor_en),
        .i_cursor_col (i_cursor_col),
        .i_cursor_row (i_cursor_row),
        .o_color      (o_color),
        .o_de         (o_de),
        .o_hsync      (o_hsync),
        .o_vsync      (o_vsync)
    );

    logic [15:0] ram [4096];
    logic [7:0]  rom [4096];

    always @(posedge clk_i) begin
        i_text_data <= ram[o_text_addr];
        i_font_data <= rom[o_font_addr];
    end

    typedef struct {
        logic        de;
        logic        hs;
        logic        vs;
        logic        chk;
        logic [11:0] taddr;
        logic [11:0] faddr;
        logic [3:0]  fg;
        logic [3:0]  bg;
        logic        bitv;
        logic        cur;
        int          h;
        int          v;
    } rec_t;

    rec_t        sb[$];
    logic [11:0] m_pal [16];
    int          m_lcnt;
    int          m_frame;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] exp_out(input rec_t r);
        logic [3:0]  fg_e;
        logic [3:0]  bg_e;
        logic [11:0] c;
        fg_e = r.cur ? r.bg : r.fg;
        bg_e = r.cur ? r.fg : r.bg;
        c = 12'h000;
        if (r.de) c = r.bitv ? m_pal[fg_e] : m_pal[bg_e];
        return {c, r.de, r.hs, r.vs};
    endfunction

    task automatic compare_outputs();
        rec_t r0;
        if (sb.size() == 5) begin
            if (sb[4].chk) check($sformatf("text_addr v%0d h%0d", sb[4].v, sb[4].h), o_text_addr, sb[4].taddr);
            if (sb[2].chk) check($sformatf("font_addr v%0d h%0d", sb[2].v, sb[2].h), o_font_addr, sb[2].faddr);
            r0 = sb.pop_front();
            check($sformatf("pixel {color,de,hs,vs} v%0d h%0d", r0.v, r0.h),
                  {o_color, o_de, o_hsync, o_vsync}, exp_out(r0));
        end
    endtask

    task automatic cycle(input int h, input int v, input logic de,
                         input logic we, input logic [3:0] widx, input logic [11:0] wcol);
        rec_t r;
        int   addr;
        int   crow;
        i_hcount    = 10'(h);
        i_vcount    = 10'(v);
        i_de        = de;
        i_hsync     = (h == HRES - 1);
        i_vsync     = (v >= VRES - 2);
        i_pal_we    = we;
        i_pal_idx   = widx;
        i_pal_color = wcol;
        crow    = m_lcnt % CELL_H;
        addr    = (m_lcnt / CELL_H) * COLS + h / 8;
        r.de    = de;
        r.hs    = i_hsync;
        r.vs    = i_vsync;
        r.chk   = de;
        r.h     = h;
        r.v     = v;
        r.taddr = 12'(addr);
        r.faddr = {ram[r.taddr][7:0], 4'(crow)};
        r.fg    = ram[r.taddr][15:12];
        r.bg    = ram[r.taddr][11:8];
        r.bitv  = rom[r.faddr][7 - (h % 8)];
        r.cur   = i_cursor_en && (((m_frame >> BLINK_LOG2) & 1) == 1)
                  && (m_lcnt / CELL_H == int'(i_cursor_row)) && (h / 8 == int'(i_cursor_col))
                  && (crow >= CELL_H - 2);
        sb.push_back(r);
        @(posedge clk_i);
        #1;
        compare_outputs();
        if (we) m_pal[widx] = wcol;
        if (h == HRES - 1) begin
            if (v == VRES - 1) begin
                m_lcnt  = 0;
                m_frame = (m_frame + 1) % (2 ** (BLINK_LOG2 + 1));
            end else begin
                m_lcnt++;
            end
        end
    endtask

    task automatic px(input int h, input int v, input logic de);
        cycle(h, v, de, 1'b0, 4'd0, 12'h000);
    endtask

    task automatic reset_cycle(input int h, input int v);
        rec_t d;
        i_hcount = 10'(h);
        i_vcount = 10'(v);
        i_de     = 1'b1;
        i_pal_we = 1'b0;
        rst_i    = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check("reset o_color", o_color, 0);
        check("reset o_de", o_de, 0);
        check("reset o_hsync", o_hsync, 0);
        check("reset o_vsync", o_vsync, 0);
        check("reset o_text_addr", o_text_addr, 0);
        check("reset o_font_addr", o_font_addr, 0);
        sb.delete();
        d = '{de: 1'b0, hs: 1'b0, vs: 1'b0, chk: 1'b0, taddr: '0, faddr: '0,
              fg: '0, bg: '0, bitv: 1'b0, cur: 1'b0, h: h, v: v};
        repeat (4) sb.push_back(d);
        m_lcnt  = 0;
        m_frame = 0;
        for (int i = 0; i < 16; i++) m_pal[i] = {4'(i), 4'(i), 4'(i)};
    endtask

    task automatic do_line(input int v, input int lo, input int hi);
        for (int h = lo; h <= hi; h++) px(h, v, 1'b1);
        px(HRES - 1, v, 1'b0);
    endtask

    task automatic do_frame(input bit detail);
        for (int v = 0; v < VRES; v++) begin
            if (detail && (v == 0 || (v >= 9 && v <= 12))) do_line(v, 0, 23);
            else do_line(v, 1, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            ram[i] = 16'($urandom);
            rom[i] = 8'($urandom);
        end
        ram[0] = 16'hF041;
        ram[1] = 16'h0541;
        ram[2] = 16'hA3C2;
        rom[12'h410] = 8'h81;
        rom[12'hC2A] = 8'hF0;
        rom[12'hC2B] = 8'hF0;
        i_cursor_en  = 1'b1;
        i_cursor_col = 7'd2;
        i_cursor_row = 6'd0;

        reset_cycle(0, 0);
        repeat (10) px(0, 0, 1'b0);

        // Frames 0..64: blink off, on from 32, off again after the counter wraps.
        do_frame(1'b1);
        for (int f = 1; f <= 30; f++) do_frame(1'b0);
        do_frame(1'b1);
        do_frame(1'b1);
        for (int f = 33; f <= 62; f++) do_frame(1'b0);
        do_frame(1'b1);
        do_frame(1'b1);

        // Palette write landing on the same cycle as the first pixel's lookup.
        for (int h = 0; h <= 23; h++) cycle(h, 0, 1'b1, (h == 4), 4'd15, 12'h0F0);
        px(HRES - 1, 0, 1'b0);
        for (int v = 1; v < VRES; v++) do_line(v, 1, 0);
        do_frame(1'b1);

        // Reset in the middle of a frame, then resynchronise at end of frame.
        for (int v = 0; v < 100; v++) do_line(v, 1, 0);
        for (int h = 296; h <= 299; h++) px(h, 100, 1'b1);
        reset_cycle(300, 100);
        for (int h = 301; h <= 310; h++) px(h, 100, 1'b1);
        px(HRES - 1, 100, 1'b0);
        do_line(101, 0, 23);
        for (int v = 102; v < VRES; v++) do_line(v, 1, 0);
        do_frame(1'b1);

        repeat (5) px(0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/text_fetch8x12.md
Name: text_fetch8x12

Overview:
- Pixel-generation stage between the VGA timing core (hcount/vcount/de/hsync/vsync) and the RGB output pins.
- Fetches character code and attribute from external text RAM, then the glyph row from external font ROM.
- Serialises the glyph bit, maps fg/bg attribute nibbles through a 16-entry writable palette and adds a blinking underline cursor.
- Outputs a 12-bit colour plus matching delayed sync/de, all with a fixed 5-cycle latency.

Parameters:
HRES, 640, visible pixels per line
VRES, 480, visible lines per frame
HSZ, 10, width of hcount input
VSZ, 10, width of vcount input
COLS, 80, text columns (HRES/8)
CELL_H, 12, scanlines per character cell
BLINK_LOG2, 5, cursor blink half-period = 2^BLINK_LOG2 frames

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  synchronous active-high reset
i_hcount  in  HSZ  horizontal pixel count from timing core
i_vcount  in  VSZ  vertical line count from timing core
i_de  in  1  display enable
i_hsync  in  1  hsync from timing core
i_vsync  in  1  vsync from timing core
o_text_addr  out  12  text RAM word address
i_text_data  in  16  [7:0] char code, [15:8] attribute (fg idx [15:12], bg idx [11:8])
o_font_addr  out  12  font ROM address {char[7:0], cell_row[3:0]}
i_font_data  in  8  glyph row, bit7 = leftmost pixel
i_pal_we  in  1  palette write strobe
i_pal_idx  in  4  palette write index
i_pal_color  in  12  palette write data, RGB444
i_cursor_en  in  1  cursor enable
i_cursor_col  in  7  cursor text column
i_cursor_row  in  6  cursor text row
o_color  out  12  RGB444 pixel
o_de  out  1  de delayed by 5
o_hsync  out  1  hsync delayed by 5
o_vsync  out  1  vsync delayed by 5

Behaviour:
- Reset (rst_i=1 at a clock edge), taking effect on the next cycle:
  - o_color, o_de, o_hsync, o_vsync, o_text_addr and o_font_addr = 0.
  - All pipeline valid, de and sync stages cleared.
  - cell_row, text_row, row_base and frame_cnt = 0.
  - Palette entry i = {i,i,i} (grey ramp: 0x000 .. 0xFFF).
- Memory contract: RAM and ROM are synchronous with 1-cycle read latency; the address presented in cycle k gives data valid in cycle k+1.
- Pipeline, for inputs sampled in cycle n:
  - n+1: o_text_addr = row_base + i_hcount[HSZ-1:3], registered. Updated only when i_de=1; otherwise it holds its value.
  - n+2: i_text_data valid. o_font_addr is registered from {char, cell_row}; attribute is captured.
  - n+4: i_font_data valid. The bit is selected as i_font_data[7 - h[2:0]], using h[2:0] carried through the pipeline.
  - n+5: o_color registered = palette[bit ? fg : bg], with fg/bg swapped if the cursor flag is set. o_color is forced to 0 when the delayed de = 0.
- de, hsync and vsync pass through a 5-stage shift register. They stay exactly aligned with o_color.
- Line counters update once per line at i_hcount == HRES-1:
  - If i_vcount == VRES-1: cell_row, text_row and row_base = 0; frame_cnt += 1, wrapping at 2^(BLINK_LOG2+1).
  - Else if cell_row == CELL_H-1: cell_row = 0, text_row += 1, row_base += COLS.
  - Else: cell_row += 1.
  - No multiplier is used; row_base is accumulated.
- Cursor flag, computed at stage n+1 and pipelined to n+5. It is set when all of the following hold:
  - i_cursor_en = 1 and frame_cnt[BLINK_LOG2] = 1.
  - text_row == i_cursor_row and i_hcount[HSZ-1:3] == i_cursor_col.
  - cell_row >= CELL_H-2.
- Palette writes:
  - A write with i_pal_we=1 in cycle k is visible from cycle k+1.
  - A write and a read of the same index in the same cycle returns the old value.
- Reset mid-frame: counters restart at 0. Text rows are misaligned until the first end-of-frame (i_vcount == VRES-1, i_hcount == HRES-1), after which they resynchronise.
- Out-of-range cursor row/col: the cursor never shows; no error is raised.

Test Plan:
- Reset, then hold i_de=0 for 10 cycles -> o_color, o_de, o_hsync, o_vsync = 0. Palette readback by drawing: idx 5 gives 0x555.
- RAM[0]=0xF041, ROM[0x410]=0x81, line 0, hcount 0..7 -> o_text_addr=0 one cycle after hcount 0 and o_font_addr=0x410. o_color reads FFF,000,000,000,000,000,000,FFF starting 5 cycles after hcount 0; o_de aligned.
- Line 12, hcount 16 -> o_text_addr=82 and o_font_addr low nibble 0. After line 479 ends, next frame line 0 hcount 0 -> o_text_addr=0.
- Cursor at col 2 row 0 enabled -> frames 0..31: no swap. Frames 32..63: lines 10-11 hcount 16..23 show fg/bg swapped; lines 0-9 unchanged.
- Write palette[15]=0x0F0 -> subsequent fg pixels with attr fg=15 output 0x0F0. A write in the same cycle as the n+5 lookup outputs the old 0xFFF.
- Assert rst_i for 1 cycle at line 100, hcount 300 -> all outputs 0 the next cycle. After the end of that frame, line 0 addressing restarts at 0.
